// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the 1-to-N valid/ready stream demultiplexer.
package stream_demux_pkg;
  localparam int DROP_CNT_W = 16;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slice_state_e;
endpackage

// File: rtl/stream_reg_slice.sv
// One-entry valid/ready register slice; accepts a new beat in the same cycle it drains.
module stream_reg_slice
  import stream_demux_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  can_accept,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);
  slice_state_e state_q, state_d;

  assign out_valid  = (state_q == FULL);
  assign can_accept = ~out_valid | out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (load) state_d = FULL;
      FULL:    if (out_ready && !load) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // Data only moves on load, so it is held while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     out_data <= '0;
    else if (load) out_data <= load_data;
  end
endmodule

// File: rtl/stream_demux.sv
// 1-to-N valid/ready demux with per-channel register slices and an out-of-range drop path.
// Optional broadcast beats (in_bcast) enabled by defining STREAM_DEMUX_BCAST_EN.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int N_OUT      = 4,
  parameter int SEL_W      = $clog2(N_OUT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic [DATA_WIDTH-1:0] in_data,
`ifdef STREAM_DEMUX_BCAST_EN
  input  logic                  in_bcast,
`endif
  output logic [N_OUT-1:0]      out_valid,
  input  logic [N_OUT-1:0]      out_ready,
  output logic [DATA_WIDTH-1:0] out_data [N_OUT],
  output logic                  sel_err,
  output logic [DROP_CNT_W-1:0] drop_cnt
);
  logic [N_OUT-1:0] can_accept;
  logic [N_OUT-1:0] load;
  logic [31:0]      sel_ext;
  logic             sel_ok, sel_ready, bcast, fire, drop;

`ifdef STREAM_DEMUX_BCAST_EN
  assign bcast = in_bcast;
`else
  assign bcast = 1'b0;
`endif

  // Widened compare keeps the range check meaningful when N_OUT is a power of two.
  assign sel_ext = 32'(in_sel);
  assign sel_ok  = (sel_ext < 32'(N_OUT));

  always_comb begin
    sel_ready = 1'b0;
    for (int i = 0; i < N_OUT; i++)
      if (sel_ext == 32'(i)) sel_ready = can_accept[i];
  end

  assign in_ready = bcast  ? &can_accept :
                    sel_ok ? sel_ready   : 1'b1;
  assign fire     = in_valid & in_ready;
  assign drop     = fire & ~bcast & ~sel_ok;

  for (genvar i = 0; i < N_OUT; i++) begin : g_slice
    assign load[i] = fire & (bcast | (sel_ok & (sel_ext == i)));

    stream_reg_slice #(.DATA_WIDTH(DATA_WIDTH)) u_slice (
      .clk        (clk),
      .reset      (reset),
      .load       (load[i]),
      .load_data  (in_data),
      .can_accept (can_accept[i]),
      .out_valid  (out_valid[i]),
      .out_ready  (out_ready[i]),
      .out_data   (out_data[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_err  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      sel_err <= drop;
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
    end
  end
endmodule
